miriscv_lsu: RTL

Load-store unit for the miriscv core. It takes the memory request from the decoder (request, write enable, size), the ALU-computed address and the rs2 store data, and sequences one access on the data-memory request/grant/response interface. It stalls the core for the whole access, builds byte enables and replicated store data, and returns aligned, sign/zero-extended load data to the write-back mux. It sits between the execute stage and the data memory, which it does not share with any other requester.

---
 rtl/miriscv_lsu_pkg.sv | 29 ++
 rtl/miriscv_lsu_align.sv | 57 +++++
 rtl/miriscv_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/miriscv_lsu_pkg.sv
// Shared size codes, LSU state encoding and request-validity helpers for the miriscv LSU.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [2:0] LSU_IDLE = 3'd0;
  localparam logic [2:0] LSU_REQ  = 3'd1;
  localparam logic [2:0] LSU_RSP  = 3'd2;
  localparam logic [2:0] LSU_DONE = 3'd3;
  localparam logic [2:0] LSU_ERR  = 3'd4;

  function automatic logic size_valid(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: misaligned = off[0];
      LDST_W:          misaligned = (off != 2'b00);
      default:         misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Byte-enable generation, store-data replication and load extraction/extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [1:0]  ld_off;
  logic [31:0] ld_shift;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      2'd0: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'd1: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Half accesses only honour addr[1]; words ignore the low bits entirely.
  always_comb begin
    ld_off = 2'b00;
    case (ld_size_i)
      LDST_B, LDST_BU: ld_off = ld_off_i;
      LDST_H, LDST_HU: ld_off = {ld_off_i[1], 1'b0};
      default:         ld_off = 2'b00;
    endcase
    ld_shift = ld_rdata_i >> {ld_off, 3'b000};
  end

  always_comb begin
    ld_data_o = ld_shift;
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      LDST_BU: ld_data_o = {24'b0, ld_shift[7:0]};
      LDST_H:  ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      LDST_HU: ld_data_o = {16'b0, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load-store unit: one access at a time on the req/gnt/rvalid bus, with timeout.
// Optional MIRISCV_LSU_MISALIGN_EN rejects misaligned half/word accesses before the bus.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic [2:0]  lsu_state_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic [15:0] TO_LAST = 16'(RSP_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        data_req_q, data_we_q;
  logic [3:0]  data_be_q;
  logic [31:0] data_addr_q, data_wdata_q, lsu_data_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        bad_req, accept;

`ifdef MIRISCV_LSU_MISALIGN_EN
  assign bad_req = !size_valid(lsu_size_i) || misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
  assign bad_req = !size_valid(lsu_size_i);
`endif
  assign accept = (state_q == LSU_IDLE) && lsu_req_i && !bad_req;

  miriscv_lsu_align u_align (
    .st_size_i  (lsu_size_i[1:0]),
    .st_off_i   (lsu_addr_i[1:0]),
    .st_data_i  (lsu_data_i),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_size_i  (size_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (data_rdata_i),
    .ld_data_o  (ld_data)
  );

  // Bus handshake: a request is accepted in the cycle data_req_o and data_gnt_i are both 1;
  // the bus fields hold until then. A load's data arrives on a later data_rvalid_i cycle,
  // which is only honoured in RSP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (bad_req) begin
            state_d = LSU_ERR;
          end else begin
            state_d = LSU_REQ;
            cnt_d   = '0;
          end
        end
      end
      LSU_REQ: begin
        if (data_gnt_i) begin
          state_d = data_we_q ? LSU_DONE : LSU_RSP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = LSU_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LSU_RSP: begin
        if (data_rvalid_i) begin
          state_d = LSU_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = LSU_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      lsu_data_q   <= '0;
      size_q       <= '0;
      off_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_req_q <= (state_d == LSU_REQ);
      if (accept) begin
        data_we_q    <= lsu_we_i;
        data_be_q    <= st_be;
        data_addr_q  <= {lsu_addr_i[31:2], 2'b00};
        data_wdata_q <= st_wdata;
        size_q       <= lsu_size_i;
        off_q        <= lsu_addr_i[1:0];
      end
      if ((state_q == LSU_RSP) && data_rvalid_i) begin
        lsu_data_q <= ld_data;
      end
    end
  end

  assign lsu_stall_req_o = lsu_req_i && !rst_i && (state_q != LSU_DONE) && (state_q != LSU_ERR);
  assign lsu_err_o       = (state_q == LSU_ERR);
  assign lsu_state_o     = state_q;
  assign lsu_data_o      = lsu_data_q;
  assign data_req_o      = data_req_q;
  assign data_we_o       = data_we_q;
  assign data_be_o       = data_be_q;
  assign data_addr_o     = data_addr_q;
  assign data_wdata_o    = data_wdata_q;

endmodule
